spike_dispatcher: RTL and testbench

- Sits between network_interface and the per-neuron mac units.
- Buffers outgoing 24-bit spike packets ({origin[23:12], destination[11:0]}) in a FIFO and delivers them one per cycle as a registered source-address strobe to the destination neuron's accumulator.
- Replaces the ad-hoc packet-to-source_address routing at the accelerator top. Adds backpressure, destination range checking and a drop counter.

---
 rtl/spike_dispatcher.sv | 147 ++++++++++++++
 tb/tb_spike_dispatcher.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/spike_dispatcher.sv
// ---------------------------------------------------------------------------
// spike_dispatcher
// Buffers 24-bit spike packets {origin, destination} from the network
// interface in a FIFO and presents them, one per cycle, as a registered
// source-address strobe to the destination neuron's mac unit. Out-of-range
// destinations are discarded and counted.
//
// Ports:
//   CLK, RESET_N     clock, asynchronous active-low reset
//   packet           {origin[2*ADDR_W-1:ADDR_W], destination[ADDR_W-1:0]}
//   packet_valid     packet is valid this cycle
//   packet_ready     FIFO can accept a packet this cycle
//   flush            synchronous discard of queued and pending packets
//   source_address   origin address of the pending dispatch
//   dest_select      one-hot destination strobe (qualified by dispatch_valid)
//   dispatch_valid   source_address/dest_select are valid
//   dispatch_ready   accumulators accept the dispatch this cycle
//   fifo_count       entries queued, excluding the output register
//   drop_count       saturating count of out-of-range packets
//   idle             nothing queued, nothing pending, flush low
// ---------------------------------------------------------------------------
module spike_dispatcher #(
    parameter int unsigned NUM_NEURONS = 10,
    parameter int unsigned ADDR_W      = 12,
    parameter int unsigned BASE_ADDR   = 0,
    parameter int unsigned FIFO_DEPTH  = 8
) (
    input  logic                          CLK,
    input  logic                          RESET_N,
    input  logic [2*ADDR_W-1:0]           packet,
    input  logic                          packet_valid,
    output logic                          packet_ready,
    input  logic                          flush,
    output logic [ADDR_W-1:0]             source_address,
    output logic [NUM_NEURONS-1:0]        dest_select,
    output logic                          dispatch_valid,
    input  logic                          dispatch_ready,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic [7:0]                    drop_count,
    output logic                          idle
);

    localparam int unsigned PKT_W = 2 * ADDR_W;
    localparam int unsigned IDX_W = $clog2(FIFO_DEPTH);
    localparam int unsigned PTR_W = IDX_W + 1;

    logic [PKT_W-1:0]       r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]       r_wptr;
    logic [PTR_W-1:0]       r_rptr;
    logic                   r_alive;
    logic                   r_dv;
    logic [ADDR_W-1:0]      r_addr;
    logic [NUM_NEURONS-1:0] r_sel;
    logic [7:0]             r_drop;

    logic                   w_empty;
    logic                   w_full;
    logic                   w_ready;
    logic                   w_push;
    logic                   w_slot;
    logic                   w_pop;
    logic [PKT_W-1:0]       w_head;
    logic [ADDR_W-1:0]      w_idx;
    logic                   w_in_range;
    logic [NUM_NEURONS-1:0] w_onehot;

    // Pointer-based occupancy: extra MSB distinguishes full from empty
    assign w_empty = (r_wptr == r_rptr);
    assign w_full  = (r_wptr[PTR_W-1] != r_rptr[PTR_W-1]) &&
                     (r_wptr[IDX_W-1:0] == r_rptr[IDX_W-1:0]);

    // r_alive keeps packet_ready low until the first edge after reset
    assign w_ready = r_alive && !w_full && !flush;
    assign w_push  = packet_valid && w_ready;

    // Output register is free when empty or its dispatch is being accepted
    assign w_slot  = !r_dv || dispatch_ready;
    assign w_pop   = !w_empty && w_slot && !flush;

    // Destination decode of the FIFO head
    assign w_head     = r_mem[r_rptr[IDX_W-1:0]];
    assign w_idx      = w_head[ADDR_W-1:0] - ADDR_W'(BASE_ADDR);
    assign w_in_range = (32'(w_idx) < NUM_NEURONS);
    assign w_onehot   = NUM_NEURONS'(1) << w_idx;

    // Packet storage; contents need no reset since pointers gate their use
    always_ff @(posedge CLK) begin
        if (w_push) begin
            r_mem[r_wptr[IDX_W-1:0]] <= packet;
        end
    end

    // Pointers, output register and drop counter
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_alive <= 1'b0;
            r_dv    <= 1'b0;
            r_addr  <= '0;
            r_sel   <= '0;
            r_drop  <= '0;
        end else begin
            r_alive <= 1'b1;
            if (flush) begin
                r_wptr <= '0;
                r_rptr <= '0;
                r_dv   <= 1'b0;
                r_addr <= '0;
                r_sel  <= '0;
            end else begin
                if (w_push) begin
                    r_wptr <= r_wptr + PTR_W'(1);
                end
                if (w_pop) begin
                    r_rptr <= r_rptr + PTR_W'(1);
                    if (w_in_range) begin
                        r_dv   <= 1'b1;
                        r_addr <= w_head[PKT_W-1:ADDR_W];
                        r_sel  <= w_onehot;
                    end else begin
                        // Dropped head uses this cycle; output goes empty
                        r_dv   <= 1'b0;
                        r_addr <= '0;
                        r_sel  <= '0;
                        if (r_drop != 8'hFF) begin
                            r_drop <= r_drop + 8'd1;
                        end
                    end
                end else if (r_dv && dispatch_ready) begin
                    r_dv   <= 1'b0;
                    r_addr <= '0;
                    r_sel  <= '0;
                end
            end
        end
    end

    assign packet_ready   = w_ready;
    assign source_address = r_addr;
    assign dest_select    = r_sel;
    assign dispatch_valid = r_dv;
    assign fifo_count     = PTR_W'(r_wptr - r_rptr);
    assign drop_count     = r_drop;
    assign idle           = w_empty && !r_dv && !flush;

endmodule

// File: tb/tb_spike_dispatcher.sv
// ---------------------------------------------------------------------------
// tb_spike_dispatcher
// Directed bench: a table of single-cycle vectors followed by hand-written
// sequences for burst/backpressure, drop saturation, flush and mid-run reset.
// ---------------------------------------------------------------------------
module tb_spike_dispatcher;

    logic        CLK = 1'b0;
    logic        RESET_N;
    logic [23:0] packet;
    logic        packet_valid;
    logic        packet_ready;
    logic        flush;
    logic [11:0] source_address;
    logic [9:0]  dest_select;
    logic        dispatch_valid;
    logic        dispatch_ready;
    logic [3:0]  fifo_count;
    logic [7:0]  drop_count;
    logic        idle;

    int n_vec  = 0;
    int n_miss = 0;

    spike_dispatcher #(
        .NUM_NEURONS(10),
        .ADDR_W     (12),
        .BASE_ADDR  (0),
        .FIFO_DEPTH (8)
    ) dut (
        .CLK           (CLK),
        .RESET_N       (RESET_N),
        .packet        (packet),
        .packet_valid  (packet_valid),
        .packet_ready  (packet_ready),
        .flush         (flush),
        .source_address(source_address),
        .dest_select   (dest_select),
        .dispatch_valid(dispatch_valid),
        .dispatch_ready(dispatch_ready),
        .fifo_count    (fifo_count),
        .drop_count    (drop_count),
        .idle          (idle)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic        valid;
        logic [23:0] pkt;
        logic        drdy;
        logic        fl;
        logic        e_dv;
        logic [11:0] e_addr;
        logic [9:0]  e_sel;
        logic [3:0]  e_cnt;
        logic        e_rdy;
        logic        e_idle;
        logic [7:0]  e_drop;
    } vec_t;

    vec_t tbl [15];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk_out(input string tag, input logic dv, input logic [11:0] addr,
                           input logic [9:0] sel, input logic [3:0] cnt, input logic rdy,
                           input logic idl, input logic [7:0] drp);
        chk({tag, ".dispatch_valid"}, 32'(dispatch_valid), 32'(dv));
        chk({tag, ".source_address"}, 32'(source_address), 32'(addr));
        chk({tag, ".dest_select"},    32'(dest_select),    32'(sel));
        chk({tag, ".fifo_count"},     32'(fifo_count),     32'(cnt));
        chk({tag, ".packet_ready"},   32'(packet_ready),   32'(rdy));
        chk({tag, ".idle"},           32'(idle),           32'(idl));
        chk({tag, ".drop_count"},     32'(drop_count),     32'(drp));
    endtask

    initial begin
        int acc;

        //            valid pkt              drdy fl  dv addr    sel     cnt rdy idl drop
        tbl[0]  = '{1'b1, {12'h000, 12'd3}, 1'b1, 1'b0, 1'b0, 12'h000, 10'h000, 4'd1, 1'b1, 1'b0, 8'd0};
        tbl[1]  = '{1'b0, 24'h0,            1'b1, 1'b0, 1'b1, 12'h000, 10'h008, 4'd0, 1'b1, 1'b0, 8'd0};
        tbl[2]  = '{1'b0, 24'h0,            1'b1, 1'b0, 1'b0, 12'h000, 10'h000, 4'd0, 1'b1, 1'b1, 8'd0};
        tbl[3]  = '{1'b1, {12'h007, 12'd10},1'b1, 1'b0, 1'b0, 12'h000, 10'h000, 4'd1, 1'b1, 1'b0, 8'd0};
        tbl[4]  = '{1'b1, {12'h007, 12'd9}, 1'b1, 1'b0, 1'b0, 12'h000, 10'h000, 4'd1, 1'b1, 1'b0, 8'd1};
        tbl[5]  = '{1'b0, 24'h0,            1'b1, 1'b0, 1'b1, 12'h007, 10'h200, 4'd0, 1'b1, 1'b0, 8'd1};
        tbl[6]  = '{1'b0, 24'h0,            1'b1, 1'b0, 1'b0, 12'h000, 10'h000, 4'd0, 1'b1, 1'b1, 8'd1};
        tbl[7]  = '{1'b1, {12'h123, 12'd0}, 1'b1, 1'b0, 1'b0, 12'h000, 10'h000, 4'd1, 1'b1, 1'b0, 8'd1};
        tbl[8]  = '{1'b1, {12'h456, 12'd1}, 1'b1, 1'b0, 1'b1, 12'h123, 10'h001, 4'd1, 1'b1, 1'b0, 8'd1};
        tbl[9]  = '{1'b0, 24'h0,            1'b1, 1'b0, 1'b1, 12'h456, 10'h002, 4'd0, 1'b1, 1'b0, 8'd1};
        tbl[10] = '{1'b0, 24'h0,            1'b0, 1'b0, 1'b1, 12'h456, 10'h002, 4'd0, 1'b1, 1'b0, 8'd1};
        tbl[11] = '{1'b0, 24'h0,            1'b1, 1'b0, 1'b0, 12'h000, 10'h000, 4'd0, 1'b1, 1'b1, 8'd1};
        tbl[12] = '{1'b1, {12'h0AB, 12'd4}, 1'b0, 1'b0, 1'b0, 12'h000, 10'h000, 4'd1, 1'b1, 1'b0, 8'd1};
        tbl[13] = '{1'b1, {12'h0CD, 12'd5}, 1'b0, 1'b1, 1'b0, 12'h000, 10'h000, 4'd0, 1'b0, 1'b0, 8'd1};
        tbl[14] = '{1'b0, 24'h0,            1'b1, 1'b0, 1'b0, 12'h000, 10'h000, 4'd0, 1'b1, 1'b1, 8'd1};

        RESET_N        = 1'b0;
        packet         = '0;
        packet_valid   = 1'b0;
        flush          = 1'b0;
        dispatch_ready = 1'b1;

        // Reset state, held across edges
        #12;
        chk_out("reset", 1'b0, 12'h0, 10'h0, 4'd0, 1'b0, 1'b1, 8'd0);
        #10;
        RESET_N = 1'b1;
        #1;
        chk("reset_release.packet_ready_before_edge", 32'(packet_ready), 32'd0);
        step();
        chk("reset_release.packet_ready_after_edge", 32'(packet_ready), 32'd1);

        // Table-driven vectors: inputs applied, one edge, outputs compared
        for (int i = 0; i < 15; i++) begin
            packet_valid   = tbl[i].valid;
            packet         = tbl[i].pkt;
            dispatch_ready = tbl[i].drdy;
            flush          = tbl[i].fl;
            step();
            chk_out($sformatf("vec%0d", i), tbl[i].e_dv, tbl[i].e_addr, tbl[i].e_sel,
                    tbl[i].e_cnt, tbl[i].e_rdy, tbl[i].e_idle, tbl[i].e_drop);
        end

        // Burst of 10 with dispatch_ready low: 1 pending + 8 queued
        dispatch_ready = 1'b0;
        acc = 0;
        for (int i = 0; i < 10; i++) begin
            packet       = {12'(i), 12'd5};
            packet_valid = 1'b1;
            if (packet_ready) acc++;
            step();
        end
        packet_valid = 1'b0;
        chk("burst.accepted", 32'(acc), 32'd9);
        chk_out("burst.full", 1'b1, 12'h000, 10'h020, 4'd8, 1'b0, 1'b0, 8'd1);
        dispatch_ready = 1'b1;
        for (int k = 0; k < 9; k++) begin
            chk($sformatf("burst.drain%0d.dispatch_valid", k), 32'(dispatch_valid), 32'd1);
            chk($sformatf("burst.drain%0d.source_address", k), 32'(source_address), 32'(k));
            chk($sformatf("burst.drain%0d.dest_select", k), 32'(dest_select), 32'h020);
            step();
        end
        chk_out("burst.done", 1'b0, 12'h000, 10'h000, 4'd0, 1'b1, 1'b1, 8'd1);

        // Backpressure hold for 5 cycles, next load only after acceptance
        dispatch_ready = 1'b0;
        packet_valid   = 1'b1;
        packet         = {12'h0AA, 12'd2};
        step();
        packet         = {12'h0BB, 12'd6};
        step();
        packet_valid   = 1'b0;
        for (int k = 0; k < 5; k++) begin
            step();
            chk_out($sformatf("hold%0d", k), 1'b1, 12'h0AA, 10'h004, 4'd1, 1'b1, 1'b0, 8'd1);
        end
        dispatch_ready = 1'b1;
        step();
        chk_out("hold.next", 1'b1, 12'h0BB, 10'h040, 4'd0, 1'b1, 1'b0, 8'd1);
        step();
        chk_out("hold.empty", 1'b0, 12'h000, 10'h000, 4'd0, 1'b1, 1'b1, 8'd1);

        // 260 out-of-range packets saturate the drop counter
        for (int i = 0; i < 260; i++) begin
            packet_valid = 1'b1;
            packet       = {12'h007, 12'hFFF};
            step();
            if (i == 100) chk("sat.mid_drop_count", 32'(drop_count), 32'd101);
        end
        packet_valid = 1'b0;
        step();
        chk_out("sat.final", 1'b0, 12'h000, 10'h000, 4'd0, 1'b1, 1'b1, 8'd255);

        // Flush with 4 queued plus 1 pending
        dispatch_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            packet_valid = 1'b1;
            packet       = {12'(16 + i), 12'(i)};
            step();
        end
        packet_valid = 1'b0;
        chk_out("flush.before", 1'b1, 12'h010, 10'h001, 4'd4, 1'b1, 1'b0, 8'd255);
        flush        = 1'b1;
        packet_valid = 1'b1;
        #1;
        chk("flush.packet_ready_during", 32'(packet_ready), 32'd0);
        step();
        chk_out("flush.edge", 1'b0, 12'h000, 10'h000, 4'd0, 1'b0, 1'b0, 8'd255);
        flush        = 1'b0;
        packet_valid = 1'b0;
        #1;
        chk_out("flush.after", 1'b0, 12'h000, 10'h000, 4'd0, 1'b1, 1'b1, 8'd255);

        // Reset mid-operation: 1 pending + 3 queued, asserted between edges
        for (int i = 0; i < 4; i++) begin
            packet_valid = 1'b1;
            packet       = {12'(32 + i), 12'(i + 1)};
            step();
        end
        packet_valid = 1'b0;
        chk_out("rst_mid.before", 1'b1, 12'h020, 10'h002, 4'd3, 1'b1, 1'b0, 8'd255);
        #2;
        RESET_N = 1'b0;
        #1;
        chk_out("rst_mid.async", 1'b0, 12'h000, 10'h000, 4'd0, 1'b0, 1'b1, 8'd0);
        step();
        #3;
        RESET_N = 1'b1;
        #1;
        chk("rst_mid.packet_ready_before_edge", 32'(packet_ready), 32'd0);
        step();
        chk("rst_mid.packet_ready_after_edge", 32'(packet_ready), 32'd1);
        dispatch_ready = 1'b1;
        packet_valid   = 1'b1;
        packet         = {12'h321, 12'd7};
        step();
        packet_valid   = 1'b0;
        chk_out("rst_mid.push", 1'b0, 12'h000, 10'h000, 4'd1, 1'b1, 1'b0, 8'd0);
        step();
        chk_out("rst_mid.dispatch", 1'b1, 12'h321, 10'h080, 4'd0, 1'b1, 1'b0, 8'd0);
        step();
        chk_out("rst_mid.idle", 1'b0, 12'h000, 10'h000, 4'd0, 1'b1, 1'b1, 8'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
